// File: rtl/disp_conv_sched.sv
// disp_conv_sched: four-digit multiplexed display scanner with a periodic
// binary-to-BCD conversion scheduler. The scan runs freely. The scheduler
// hands the sampled count to an external converter and latches the returned
// BCD digits into the display register.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no conversion in flight, waiting for a pending sample
// START | operand held on conv_bin, conv_en pulsed for this one cycle
// WAIT  | waiting for an armed conv_rdy, bounded by TIMEOUT cycles
// LATCH | conv_bcd copied into the display register
module disp_conv_sched #(
    parameter int REFRESH_DIV = 100000,
    parameter int SAMPLE_DIV  = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] value,
    input  logic        conv_rdy,
    input  logic [15:0] conv_bcd,
    output logic        conv_en,
    output logic [11:0] conv_bin,
    output logic [3:0]  digit,
    output logic [1:0]  an_sel,
    output logic [3:0]  anode,
    output logic        busy,
    output logic        err
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PW-1:0] PRESC_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST   = FW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    an_sel_q, an_sel_d;
    logic [FW-1:0] frame_q, frame_d;

    logic          pending_q, pending_d;
    logic          armed_q, armed_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [11:0]   bin_q, bin_d;
    logic [15:0]   disp_q, disp_d;
    logic          err_q, err_d;

    logic presc_wrap;
    logic frame_step;
    logic sample_tick;
    logic accept;
    logic timeout_hit;

    // Scan timing: prescaler, digit index and frame counter, independent of the FSM.
    always_comb begin
        presc_wrap  = (presc_q == PRESC_LAST);
        frame_step  = presc_wrap && (an_sel_q == 2'd3);
        sample_tick = frame_step && (frame_q == FRAME_LAST);

        presc_d  = presc_wrap ? '0 : presc_q + 1'b1;
        an_sel_d = presc_wrap ? an_sel_q + 2'd1 : an_sel_q;

        frame_d = frame_q;
        if (frame_step) begin
            frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
        end
    end

    // Scan registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            an_sel_q <= 2'd0;
            frame_q  <= '0;
        end else begin
            presc_q  <= presc_d;
            an_sel_q <= an_sel_d;
            frame_q  <= frame_d;
        end
    end

    // A high conv_rdy counts only after it has been seen low in this WAIT,
    // so a level left over from the previous conversion cannot be accepted.
    always_comb begin
        accept      = (state_q == S_WAIT) && conv_rdy && armed_q;
        timeout_hit = (state_q == S_WAIT) && !accept && (tcnt_q == TIMEOUT_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (accept) begin
                    state_d = S_LATCH;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_LATCH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: start pulse and busy flag decode directly from state.
    always_comb begin
        conv_en = (state_q == S_START);
        busy    = (state_q != S_IDLE);
    end

    // Scheduler datapath. The operand is captured on the way into START so it
    // is already valid while conv_en is high. A sample tick wins over the
    // pending clear, so a tick landing on the consuming cycle is not lost.
    always_comb begin
        pending_d = pending_q;
        armed_d   = armed_q;
        tcnt_d    = tcnt_q;
        bin_d     = bin_q;
        disp_d    = disp_q;
        err_d     = err_q;

        if ((state_q == S_IDLE) && pending_q) begin
            pending_d = 1'b0;
            bin_d     = value;
        end

        if (state_q == S_START) begin
            armed_d = 1'b0;
            tcnt_d  = '0;
        end

        if (state_q == S_WAIT) begin
            if (!conv_rdy) begin
                armed_d = 1'b1;
            end
            if (!accept && !timeout_hit) begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end

        if (timeout_hit) begin
            err_d = 1'b1;
        end

        if (state_q == S_LATCH) begin
            disp_d = conv_bcd;
        end

        if (sample_tick) begin
            pending_d = 1'b1;
        end
    end

    // Scheduler registers; pending comes out of reset set so a conversion
    // starts on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b1;
            armed_q   <= 1'b0;
            tcnt_q    <= '0;
            bin_q     <= 12'd0;
            disp_q    <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            armed_q   <= armed_d;
            tcnt_q    <= tcnt_d;
            bin_q     <= bin_d;
            disp_q    <= disp_d;
            err_q     <= err_d;
        end
    end

    // Display drive: digit mux and active-low anode decode from registers only.
    always_comb begin
        digit = 4'd0;
        anode = 4'b1111;
        case (an_sel_q)
            2'd0: begin
                digit = disp_q[3:0];
                anode = 4'b1110;
            end
            2'd1: begin
                digit = disp_q[7:4];
                anode = 4'b1101;
            end
            2'd2: begin
                digit = disp_q[11:8];
                anode = 4'b1011;
            end
            2'd3: begin
                digit = disp_q[15:12];
                anode = 4'b0111;
            end
            default: begin
                digit = 4'd0;
                anode = 4'b1111;
            end
        endcase
    end

    assign conv_bin = bin_q;
    assign an_sel   = an_sel_q;
    assign err      = err_q;

endmodule
